// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite pixel writer: line buffer entry layout,
// x position width and the default visible line width.
package sprite_pkg;

  localparam int X_W                = 10;
  localparam int ENTRY_W            = 16;
  localparam int LINE_WIDTH_DEFAULT = 640;

  // Line buffer entry fields; bits above the mask are always written as zero.
  localparam int COLOR_LSB = 0;
  localparam int COLOR_W   = 8;
  localparam int Z_LSB     = 8;
  localparam int Z_W       = 2;
  localparam int MASK_LSB  = 10;
  localparam int MASK_W    = 4;

  // Assemble a line buffer entry from its fields, leaving unused bits zero.
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [MASK_W-1:0]  mask,
    input logic [Z_W-1:0]     z,
    input logic [COLOR_W-1:0] color
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[COLOR_LSB +: COLOR_W] = color;
    e[Z_LSB +: Z_W]         = z;
    e[MASK_LSB +: MASK_W]   = mask;
    return e;
  endfunction

endpackage

// File: rtl/sprite_pixel_writer.sv
// Sprite pixel writer: merges a stream of sprite pixels into a line buffer
// with a depth test, accumulates sprite collision bits per line and reports
// them once the write pipeline has drained after line_end.
// Optional feature macro: SPRITE_COLLISION_EN (collision masks tracked and
// reported); when undefined, written mask bits and coll_mask are zero.
module sprite_pixel_writer
  import sprite_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [X_W-1:0]     pix_x,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic [Z_W-1:0]     pix_z,
  input  logic [MASK_W-1:0]  pix_cmask,
  input  logic               line_end,
  output logic [X_W-1:0]     renderer_rd_idx,
  input  logic [ENTRY_W-1:0] renderer_rd_data,
  output logic [X_W-1:0]     renderer_wr_idx,
  output logic [ENTRY_W-1:0] renderer_wr_data,
  output logic               renderer_wr_en,
  output logic               coll_valid,
  output logic [MASK_W-1:0]  coll_mask,
  output logic               busy
);

  logic               accept;
  logic               keep;

  // Stage 1: accepted pixel waiting for its line buffer entry.
  logic               s1_valid_reg;
  logic [X_W-1:0]     s1_x_reg;
  logic [COLOR_W-1:0] s1_color_reg;
  logic [Z_W-1:0]     s1_z_reg;
  logic [MASK_W-1:0]  s1_cmask_reg;

  // Stage 2: registered write to the line buffer.
  logic               wr_en_reg;
  logic [X_W-1:0]     wr_idx_reg;
  logic [ENTRY_W-1:0] wr_data_reg;

  // Copy of the write issued one cycle earlier; the buffer's registered read
  // cannot have observed it yet.
  logic               prev_en_reg;
  logic [X_W-1:0]     prev_idx_reg;
  logic [ENTRY_W-1:0] prev_data_reg;

  logic               pending_reg;

  logic [ENTRY_W-1:0] cur_entry;
  logic [ENTRY_W-1:0] merged_entry;
  logic [COLOR_W-1:0] ex_color;
  logic [Z_W-1:0]     ex_z;
  logic [MASK_W-1:0]  ex_mask;
  logic [MASK_W-1:0]  merged_mask;
  logic               unused_bits;

  assign pix_ready       = ~pending_reg;
  assign accept          = pix_valid & pix_ready;
  assign keep            = accept && (pix_color != '0) && (pix_z != '0) &&
                           ({{(32-X_W){1'b0}}, pix_x} < LINE_WIDTH);
  assign renderer_rd_idx = pix_x;

  assign renderer_wr_en   = wr_en_reg;
  assign renderer_wr_idx  = wr_idx_reg;
  assign renderer_wr_data = wr_data_reg;
  assign busy             = s1_valid_reg | wr_en_reg;

  // The line is reported once nothing remains in flight; acceptance is
  // blocked while pending, so the pipeline is guaranteed to drain.
  assign coll_valid = pending_reg & ~s1_valid_reg & ~wr_en_reg;

  // Newest view of the entry at the stage-1 x: in-progress write first,
  // then last cycle's write, then the buffer's read data.
  always_comb begin
    cur_entry = renderer_rd_data;
    if (wr_en_reg && (wr_idx_reg == s1_x_reg)) begin
      cur_entry = wr_data_reg;
    end else if (prev_en_reg && (prev_idx_reg == s1_x_reg)) begin
      cur_entry = prev_data_reg;
    end
  end

  assign ex_color = cur_entry[COLOR_LSB +: COLOR_W];
  assign ex_z     = cur_entry[Z_LSB +: Z_W];
  assign ex_mask  = cur_entry[MASK_LSB +: MASK_W];

`ifdef SPRITE_COLLISION_EN
  logic [MASK_W-1:0] hit_mask;
  logic [MASK_W-1:0] sticky_reg;

  assign merged_mask = ex_mask | s1_cmask_reg;
  assign hit_mask    = ex_mask & s1_cmask_reg;
  assign coll_mask   = sticky_reg;
  assign unused_bits = ^cur_entry[ENTRY_W-1:MASK_LSB+MASK_W];

  // Sticky per-line collision bits, cleared right after they are reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= '0;
    end else if (coll_valid) begin
      sticky_reg <= '0;
    end else if (s1_valid_reg) begin
      sticky_reg <= sticky_reg | hit_mask;
    end
  end
`else
  assign merged_mask = '0;
  assign coll_mask   = '0;
  assign unused_bits = ^{cur_entry[ENTRY_W-1:MASK_LSB+MASK_W], ex_mask, s1_cmask_reg};
`endif

  // Depth test: a strictly nearer sprite replaces color and z; the mask
  // always merges.
  always_comb begin
    if (ex_z < s1_z_reg) begin
      merged_entry = pack_entry(merged_mask, s1_z_reg, s1_color_reg);
    end else begin
      merged_entry = pack_entry(merged_mask, ex_z, ex_color);
    end
  end

  // Stage 1 capture of pixels that will produce a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_x_reg     <= '0;
      s1_color_reg <= '0;
      s1_z_reg     <= '0;
      s1_cmask_reg <= '0;
    end else begin
      s1_valid_reg <= keep;
      if (keep) begin
        s1_x_reg     <= pix_x;
        s1_color_reg <= pix_color;
        s1_z_reg     <= pix_z;
        s1_cmask_reg <= pix_cmask;
      end
    end
  end

  // Stage 2 write register and its one-cycle-delayed copy for the bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_reg     <= 1'b0;
      wr_idx_reg    <= '0;
      wr_data_reg   <= '0;
      prev_en_reg   <= 1'b0;
      prev_idx_reg  <= '0;
      prev_data_reg <= '0;
    end else begin
      wr_en_reg     <= s1_valid_reg;
      if (s1_valid_reg) begin
        wr_idx_reg  <= s1_x_reg;
        wr_data_reg <= merged_entry;
      end
      prev_en_reg   <= wr_en_reg;
      prev_idx_reg  <= wr_idx_reg;
      prev_data_reg <= wr_data_reg;
    end
  end

  // End-of-line tracking: set by line_end, released by the report pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
    end else if (coll_valid) begin
      pending_reg <= 1'b0;
    end else if (line_end) begin
      pending_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_pixel_writer.sv
// Randomized, scoreboard-checked bench for sprite_pixel_writer. A line-array
// reference model predicts every write and every collision report; a monitor
// compares them as the DUT produces them.
module tb_sprite_pixel_writer;

  localparam int LW = 640;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [9:0]  pix_x = '0;
  logic [7:0]  pix_color = '0;
  logic [1:0]  pix_z = '0;
  logic [3:0]  pix_cmask = '0;
  logic        line_end = 1'b0;
  logic [9:0]  renderer_rd_idx;
  logic [15:0] renderer_rd_data = '0;
  logic [9:0]  renderer_wr_idx;
  logic [15:0] renderer_wr_data;
  logic        renderer_wr_en;
  logic        coll_valid;
  logic [3:0]  coll_mask;
  logic        busy;

  always #5 clk = ~clk;

  sprite_pixel_writer #(.LINE_WIDTH(LW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .pix_x            (pix_x),
    .pix_color        (pix_color),
    .pix_z            (pix_z),
    .pix_cmask        (pix_cmask),
    .line_end         (line_end),
    .renderer_rd_idx  (renderer_rd_idx),
    .renderer_rd_data (renderer_rd_data),
    .renderer_wr_idx  (renderer_wr_idx),
    .renderer_wr_data (renderer_wr_data),
    .renderer_wr_en   (renderer_wr_en),
    .coll_valid       (coll_valid),
    .coll_mask        (coll_mask),
    .busy             (busy)
  );

  // Line buffer with registered, read-before-write port.
  logic [15:0] mem [1024] = '{default: 16'h0000};
  always @(posedge clk) begin
    renderer_rd_data <= mem[renderer_rd_idx];
    if (renderer_wr_en) mem[renderer_wr_idx] <= renderer_wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [15:0] data; int cyc; } wr_exp_t;
  typedef struct { logic [3:0] mask; int cyc; } coll_exp_t;
  wr_exp_t   wr_q[$];
  coll_exp_t coll_q[$];
  wr_exp_t   mon_w;
  coll_exp_t mon_c;
  logic      mon_busy_exp;

  // Reference model: the whole line as an array, pixels applied in order.
  logic [15:0] model_line [1024] = '{default: 16'h0000};
  logic [3:0]  model_sticky = '0;
  int          last_wr_cyc = -100;
  int          coll_due = -100;
  bit          mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_pixel(input logic [9:0] x, input logic [7:0] c, input logic [1:0] z,
                             input logic [3:0] m);
    logic [15:0] old_e;
    logic [15:0] new_e;
    logic [3:0]  new_m;
    if (c == 8'h00 || z == 2'b00 || int'(x) >= LW) begin
      $display("pixel x=%0d color=%02h z=%0d dropped (cycle %0d)", x, c, z, cyc);
    end else begin
      old_e = model_line[x];
`ifdef SPRITE_COLLISION_EN
      new_m = old_e[13:10] | m;
      model_sticky = model_sticky | (old_e[13:10] & m);
`else
      new_m = 4'h0;
`endif
      if (old_e[9:8] < z) new_e = {2'b00, new_m, z, c};
      else                new_e = {2'b00, new_m, old_e[9:0]};
      model_line[x] = new_e;
      wr_q.push_back('{idx: int'(x), data: new_e, cyc: cyc + 2});
      last_wr_cyc = cyc + 2;
    end
  endtask

  task automatic model_line_end();
    int due;
    due = (last_wr_cyc + 1 > cyc + 1) ? last_wr_cyc + 1 : cyc + 1;
    coll_q.push_back('{mask: model_sticky, cyc: due});
    model_sticky = '0;
    coll_due = due;
  endtask

  // One stimulus cycle, entered and left 1 time unit after a rising edge.
  task automatic drive(input logic v, input logic [9:0] x, input logic [7:0] c,
                       input logic [1:0] z, input logic [3:0] m, input logic le);
    pix_valid = v; pix_x = x; pix_color = c; pix_z = z; pix_cmask = m; line_end = le;
    @(negedge clk);
    if (v) check("rd_idx", 32'(renderer_rd_idx), 32'(x));
    if (v && pix_ready) model_pixel(x, c, z, m);
    if (le && pix_ready) model_line_end();
    @(posedge clk); #1;
    pix_valid = 1'b0; line_end = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  // pix_ready stays low until the report cycle and returns the cycle after.
  task automatic wait_line_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("pix_ready", 32'(pix_ready), 32'(cyc > coll_due));
      if (cyc > coll_due) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_wr_en"},      32'(renderer_wr_en),   32'(0));
    check({tag, "_wr_idx"},     32'(renderer_wr_idx),  32'(0));
    check({tag, "_wr_data"},    32'(renderer_wr_data), 32'(0));
    check({tag, "_coll_valid"}, 32'(coll_valid),       32'(0));
    check({tag, "_coll_mask"},  32'(coll_mask),        32'(0));
    check({tag, "_busy"},       32'(busy),             32'(0));
    check({tag, "_pix_ready"},  32'(pix_ready),        32'(1));
  endtask

  // Monitor: compares each DUT write, collision report and busy state.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_busy_exp = (wr_q.size() != 0) && (wr_q[0].cyc <= cyc + 1);
      check("busy", 32'(busy), 32'(mon_busy_exp));
      if (renderer_wr_en) begin
        if (wr_q.size() == 0) begin
          check("unexpected_wr", 32'(1), 32'(0));
        end else begin
          mon_w = wr_q.pop_front();
          check("wr_idx",   32'(renderer_wr_idx),  32'(mon_w.idx));
          check("wr_data",  32'(renderer_wr_data), 32'(mon_w.data));
          check("wr_cycle", 32'(cyc),              32'(mon_w.cyc));
          $display("write idx=%0d data=%04h cycle=%0d", renderer_wr_idx, renderer_wr_data, cyc);
        end
      end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
        mon_w = wr_q.pop_front();
        check("missing_wr", 32'(0), 32'(1));
      end
      if (coll_valid) begin
        if (coll_q.size() == 0) begin
          check("unexpected_coll", 32'(1), 32'(0));
        end else begin
          mon_c = coll_q.pop_front();
          check("coll_mask",  32'(coll_mask), 32'(mon_c.mask));
          check("coll_cycle", 32'(cyc),       32'(mon_c.cyc));
          $display("collision report mask=%01h cycle=%0d", coll_mask, cyc);
        end
      end else if (coll_q.size() != 0 && coll_q[0].cyc <= cyc) begin
        mon_c = coll_q.pop_front();
        check("missing_coll", 32'(0), 32'(1));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int       n;
    int       sel;
    bit       ended;
    logic [9:0] x;
    logic [7:0] c;
    logic [1:0] z;
    logic [3:0] m;
    logic       le;

    #2;
    reset_checks("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single pixel into an empty buffer.
    drive(1'b1, 10'd5, 8'h12, 2'd2, 4'h1, 1'b0);
    idle(3);
    // Farther pixel over an existing entry, then end of line.
    drive(1'b1, 10'd5, 8'h34, 2'd1, 4'h2, 1'b0);
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    wait_line_done();
    // Back-to-back pixels at the same x with overlapping masks.
    drive(1'b1, 10'd9, 8'h21, 2'd1, 4'h4, 1'b0);
    drive(1'b1, 10'd9, 8'h43, 2'd3, 4'h4, 1'b0);
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    wait_line_done();
    // Discarded pixels only, then line_end with an empty pipeline.
    drive(1'b1, 10'd640, 8'h11, 2'd1, 4'h1, 1'b0);
    drive(1'b1, 10'd7,   8'h00, 2'd1, 4'h1, 1'b0);
    drive(1'b1, 10'd8,   8'h05, 2'd0, 4'h1, 1'b0);
    idle(3);
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    wait_line_done();
    // Last pixel together with line_end.
    drive(1'b1, 10'd30, 8'h77, 2'd2, 4'h8, 1'b1);
    wait_line_done();

    // Reset while a write sits in stage 2: no write, outputs at reset values.
    mon_en = 1'b0;
    pix_valid = 1'b1; pix_x = 10'd20; pix_color = 8'h55; pix_z = 2'd1; pix_cmask = 4'h1;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    reset_checks("rst_s2");
    @(posedge clk); #1;
    check("mem_untouched", 32'(mem[20]), 32'(model_line[20]));
    model_sticky = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Reset with a line_end pending: the report is discarded.
    line_end = 1'b1;
    @(posedge clk); #1;
    line_end = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_checks("rst_le");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);

    // Randomized lines in a small x window to force overlaps and bypasses.
    for (int ln = 0; ln < 30; ln++) begin
      n = $urandom_range(3, 20);
      ended = 1'b0;
      for (int p = 0; p < n; p++) begin
        sel = $urandom_range(0, 9);
        x = 10'($urandom_range(0, 15));
        if (sel == 0) x = 10'($urandom_range(630, 700));
        c = 8'($urandom_range(1, 255));
        if (sel == 1) c = 8'h00;
        z = 2'($urandom_range(1, 3));
        if (sel == 2) z = 2'd0;
        m = 4'(1 << $urandom_range(0, 3));
        le = (p == n - 1) && ($urandom_range(0, 1) == 1);
        drive(1'b1, x, c, z, m, le);
        if (le) ended = 1'b1;
        else if ($urandom_range(0, 3) == 0) idle(1);
      end
      if (!ended) drive(1'b0, '0, '0, '0, '0, 1'b1);
      wait_line_done();
    end

    idle(6);
    check("wr_queue_empty",   32'(wr_q.size()),   32'(0));
    check("coll_queue_empty", 32'(coll_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_writer.md
SPRITE_PIXEL_WRITER -- requirements
Module: sprite_pixel_writer

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 640: pixel x positions at or above this value are off-line and are discarded.
REQ-002 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port pix_valid, input, 1 bit: a sprite pixel is offered.
REQ-005 SHALL have port pix_ready, output, 1 bit: the offered pixel is accepted on this cycle.
REQ-006 SHALL have ports pix_x (input, 10 bits: line position), pix_color (input, 8 bits: palette index, 0 = transparent), pix_z (input, 2 bits: depth, 0 = disabled) and pix_cmask (input, 4 bits: collision mask).
REQ-007 SHALL have port line_end, input, 1 bit: the current line is complete; collisions are reported once the pipeline has drained.
REQ-008 SHALL have ports renderer_rd_idx (output, 10 bits), renderer_rd_data (input, 16 bits, valid 1 cycle after the index is driven), renderer_wr_idx (output, 10 bits), renderer_wr_data (output, 16 bits) and renderer_wr_en (output, 1 bit): the line buffer port.
REQ-009 SHALL have ports coll_valid (output, 1 bit: single-cycle pulse), coll_mask (output, 4 bits: collisions on the line) and busy (output, 1 bit: pixels are in flight).

Function
REQ-010 Line buffer entry format SHALL be: [7:0] color, [9:8] z, [13:10] collision mask, [15:14] zero; an all-zero entry means empty.
REQ-011 A pixel SHALL be accepted when pix_valid and pix_ready are both high; accepted throughput SHALL be one pixel per cycle.
REQ-012 An accepted pixel is dropped with no write when pix_color is 0, pix_z is 0, or pix_x is at or above LINE_WIDTH.
REQ-013 renderer_rd_idx SHALL equal pix_x combinationally in the cycle of acceptance.
REQ-014 Stage 1 (acceptance + 1): compute a merged entry from the current entry value. Stage 2 (acceptance + 2): drive renderer_wr_en, renderer_wr_idx and renderer_wr_data from registers.
REQ-015 Write rule: write {cmask_merged, pix_z, pix_color} only if the existing z is less than pix_z; otherwise write the existing color and z with cmask_merged.
REQ-016 cmask_merged SHALL equal existing mask OR pix_cmask.
REQ-017 If existing mask AND pix_cmask is non-zero, that AND result SHALL be ORed into the sticky line collision register.
REQ-018 Current-entry bypass, highest priority first:
  - (a) the stage-2 write register, when valid and the index matches;
  - (b) the write of the previous cycle, when valid and the index matches;
  - (c) renderer_rd_data.
  Back-to-back pixels at the same x SHALL therefore see each other's results.
REQ-019 On line_end: pix_ready SHALL drop in the following cycle and stay low until coll_valid.
REQ-020 After line_end, coll_valid SHALL pulse for one cycle in the first cycle after the last in-flight write; coll_mask holds the sticky value at the pulse.
REQ-021 The sticky collision register SHALL clear in the cycle after the coll_valid pulse; pix_ready SHALL reassert in that same cycle.
REQ-022 A pixel and line_end in the same cycle: the pixel is accepted and included in the line's collision result.
REQ-023 line_end with an empty pipeline: coll_valid SHALL pulse 1 cycle later.
REQ-024 busy SHALL be high whenever stage 1 or stage 2 holds a valid pixel.

Reset
REQ-025 While rst_n is low, all state SHALL clear asynchronously:
  - pipeline valids = 0;
  - renderer_wr_en = 0, renderer_wr_idx = 0, renderer_wr_data = 0;
  - coll_valid = 0, coll_mask = 0, busy = 0;
  - pix_ready = 1.
REQ-026 Pixels in flight at reset SHALL be discarded and produce no write.
REQ-027 A line_end pending at reset SHALL be discarded and produce no coll_valid pulse.

Configuration
REQ-028 With SPRITE_COLLISION_EN defined: behaviour SHALL be exactly as REQ-016 and REQ-017.
REQ-029 With SPRITE_COLLISION_EN undefined:
  - written mask bits [13:10] SHALL be 0;
  - coll_mask SHALL be constant 0;
  - the coll_valid timing is unchanged.

Structure
REQ-030 The entry field positions, the entry width (16), the x width (10) and the LINE_WIDTH default SHALL live in the shared package sprite_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; the bypass compare and the merge logic stay inline.

Verification
REQ-032 Empty buffer; pixel x=5, color=0x12, z=2, cmask=0x1 -> renderer_wr_en 2 cycles after acceptance with idx=5, data=0x0612.
REQ-033 Entry at x=5 = 0x0612; pixel x=5, color=0x34, z=1, cmask=0x2 -> data=0x0E12, coll_mask=0x0 at line_end.
REQ-034 Back-to-back pixels x=9, both cmask=0x4, z=1 then z=3 -> second write data has z=3, mask 0x4; coll_mask=0x4 after line_end.
REQ-035 Pixels with x=640, color=0, z=0 -> no renderer_wr_en; coll_valid 1 cycle after line_end with an empty pipeline.
REQ-036 line_end in the same cycle as the last pixel -> pix_ready low until coll_valid; coll_valid 1 cycle after that pixel's write cycle.
REQ-037 rst_n low during stage 2 -> no write; all outputs at reset values; pix_ready=1 immediately.
